ddr_3ch_wr_dispatch: RTL and testbench

Single-host write dispatcher that sits directly upstream of the three-channel DDR wrapper in the `core_clk` domain. It accepts one host write burst at a time and buffers the whole burst locally. It decodes the target channel from the top two address bits, then replays the command and data into the selected channel's `axiN_aw*` / `axiN_w*` port. A channel's `axiN_wready` is a pull with no matching wvalid, so a burst is never issued until all of its beats are buffered.

---
 rtl/ddr_3ch_wr_dispatch_if.sv | 55 +++++
 rtl/ddr_3ch_wr_dispatch.sv | 156 +++++++++++++++
 tb/tb_ddr_3ch_wr_dispatch.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_3ch_wr_dispatch_if.sv
// Host write port plus the three DDR channel write ports seen by the dispatcher.
// master = host/channel side, slave = dispatcher side.
interface ddr_3ch_wr_dispatch_if #(
    parameter int unsigned CTRL_ADDR_WIDTH = 28,
    parameter int unsigned DATA_W          = 256,
    parameter int unsigned ID_W            = 8,
    parameter int unsigned MAX_LEN_W       = 4
);
    logic [CTRL_ADDR_WIDTH+1:0] h_awaddr;
    logic [MAX_LEN_W-1:0]       h_awlen;
    logic [ID_W-1:0]            h_awid;
    logic                       h_awap;
    logic                       h_awvalid;
    logic                       h_awready;
    logic [DATA_W-1:0]          h_wdata;
    logic [DATA_W/8-1:0]        h_wstrb;
    logic                       h_wvalid;
    logic                       h_wready;

    logic [CTRL_ADDR_WIDTH-1:0] axi0_awaddr, axi1_awaddr, axi2_awaddr;
    logic [MAX_LEN_W-1:0]       axi0_awlen, axi1_awlen, axi2_awlen;
    logic [ID_W-1:0]            axi0_awuser_id, axi1_awuser_id, axi2_awuser_id;
    logic                       axi0_awuser_ap, axi1_awuser_ap, axi2_awuser_ap;
    logic                       axi0_awvalid, axi1_awvalid, axi2_awvalid;
    logic                       axi0_awready, axi1_awready, axi2_awready;
    logic [DATA_W-1:0]          axi0_wdata, axi1_wdata, axi2_wdata;
    logic [DATA_W/8-1:0]        axi0_wstrb, axi1_wstrb, axi2_wstrb;
    logic                       axi0_wready, axi1_wready, axi2_wready;

    modport master (
        output h_awaddr, h_awlen, h_awid, h_awap, h_awvalid, h_wdata, h_wstrb, h_wvalid,
        input  h_awready, h_wready,
        input  axi0_awaddr, axi0_awlen, axi0_awuser_id, axi0_awuser_ap, axi0_awvalid,
        input  axi0_wdata, axi0_wstrb,
        input  axi1_awaddr, axi1_awlen, axi1_awuser_id, axi1_awuser_ap, axi1_awvalid,
        input  axi1_wdata, axi1_wstrb,
        input  axi2_awaddr, axi2_awlen, axi2_awuser_id, axi2_awuser_ap, axi2_awvalid,
        input  axi2_wdata, axi2_wstrb,
        output axi0_awready, axi0_wready, axi1_awready, axi1_wready,
        output axi2_awready, axi2_wready
    );

    modport slave (
        input  h_awaddr, h_awlen, h_awid, h_awap, h_awvalid, h_wdata, h_wstrb, h_wvalid,
        output h_awready, h_wready,
        output axi0_awaddr, axi0_awlen, axi0_awuser_id, axi0_awuser_ap, axi0_awvalid,
        output axi0_wdata, axi0_wstrb,
        output axi1_awaddr, axi1_awlen, axi1_awuser_id, axi1_awuser_ap, axi1_awvalid,
        output axi1_wdata, axi1_wstrb,
        output axi2_awaddr, axi2_awlen, axi2_awuser_id, axi2_awuser_ap, axi2_awvalid,
        output axi2_wdata, axi2_wstrb,
        input  axi0_awready, axi0_wready, axi1_awready, axi1_wready,
        input  axi2_awready, axi2_wready
    );
endinterface

// File: rtl/ddr_3ch_wr_dispatch.sv
// Buffers one host write burst, then replays it to the DDR channel picked by the top two
// address bits. Define DDR3CH_DISPATCH_ERR_CNT_EN to count illegal-channel bursts in err_cnt.
module ddr_3ch_wr_dispatch #(
    parameter int unsigned CTRL_ADDR_WIDTH = 28,
    parameter int unsigned DATA_W          = 256,
    parameter int unsigned ID_W            = 8,
    parameter int unsigned MAX_LEN_W       = 4
) (
    input  logic                 core_clk,
    input  logic                 resetn,
    input  logic                 ddr_init_done,
    ddr_3ch_wr_dispatch_if.slave bus,
    output logic                 busy,
    output logic [15:0]          err_cnt
);
    localparam int unsigned Depth = 1 << MAX_LEN_W;
    localparam int unsigned EntW  = DATA_W + DATA_W / 8;

    typedef enum logic [2:0] {StIdle, StFill, StCmd, StData, StDrop} state_e;

    state_e                     state_q;
    logic                       live_q;
    logic                       busy_q;
    logic [CTRL_ADDR_WIDTH-1:0] addr_q;
    logic [MAX_LEN_W-1:0]       len_q;
    logic [ID_W-1:0]            id_q;
    logic                       ap_q;
    logic [1:0]                 sel_q;
    logic [MAX_LEN_W:0]         cnt_q;
    logic [MAX_LEN_W-1:0]       wr_ptr_q;
    logic [MAX_LEN_W-1:0]       rd_ptr_q;
    logic [EntW-1:0]            mem [Depth];
    logic [EntW-1:0]            head;

    logic aw_hs, push, pop, last, sel_awready, sel_wready;
    logic [2:0] ch_aw, ch_w;

    // live_q keeps h_awready low while reset is held, whatever ddr_init_done does.
    assign bus.h_awready = live_q & (state_q == StIdle) & ddr_init_done;
    assign bus.h_wready  = (state_q == StFill) & (cnt_q <= {1'b0, len_q});
    assign aw_hs         = bus.h_awvalid & bus.h_awready;
    assign push          = bus.h_wvalid & bus.h_wready;
    assign last          = (cnt_q == {1'b0, len_q});
    assign pop           = (state_q == StData) & sel_wready;
    assign busy          = busy_q;

    always_comb begin
        sel_awready = 1'b0;
        sel_wready  = 1'b0;
        unique case (sel_q)
            2'd0: begin sel_awready = bus.axi0_awready; sel_wready = bus.axi0_wready; end
            2'd1: begin sel_awready = bus.axi1_awready; sel_wready = bus.axi1_wready; end
            2'd2: begin sel_awready = bus.axi2_awready; sel_wready = bus.axi2_wready; end
            default: ;
        endcase
    end

    always_ff @(posedge core_clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            live_q   <= 1'b0;
            busy_q   <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            id_q     <= '0;
            ap_q     <= 1'b0;
            sel_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            live_q <= 1'b1;
            unique case (state_q)
                StIdle: if (aw_hs) begin
                    addr_q  <= bus.h_awaddr[CTRL_ADDR_WIDTH-1:0];
                    len_q   <= bus.h_awlen;
                    id_q    <= bus.h_awid;
                    ap_q    <= bus.h_awap;
                    sel_q   <= bus.h_awaddr[CTRL_ADDR_WIDTH+1 -: 2];
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= StFill;
                end
                StFill: if (push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (last) state_q <= (sel_q == 2'd3) ? StDrop : StCmd;
                end
                StCmd: if (sel_awready) begin
                    cnt_q   <= '0;
                    state_q <= StData;
                end
                StData: if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (last) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StDrop: begin
                    rd_ptr_q <= wr_ptr_q;
                    busy_q   <= 1'b0;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge core_clk) begin
        if (push) mem[wr_ptr_q] <= {bus.h_wstrb, bus.h_wdata};
    end

    assign head  = mem[rd_ptr_q];
    assign ch_aw = (state_q == StCmd) ? (3'b001 << sel_q) : 3'b000;
    assign ch_w  = (state_q == StData) ? (3'b001 << sel_q) : 3'b000;

    assign bus.axi0_awvalid   = ch_aw[0];
    assign bus.axi0_awaddr    = ch_aw[0] ? addr_q : '0;
    assign bus.axi0_awlen     = ch_aw[0] ? len_q : '0;
    assign bus.axi0_awuser_id = ch_aw[0] ? id_q : '0;
    assign bus.axi0_awuser_ap = ch_aw[0] & ap_q;
    assign bus.axi0_wdata     = ch_w[0] ? head[DATA_W-1:0] : '0;
    assign bus.axi0_wstrb     = ch_w[0] ? head[EntW-1:DATA_W] : '0;

    assign bus.axi1_awvalid   = ch_aw[1];
    assign bus.axi1_awaddr    = ch_aw[1] ? addr_q : '0;
    assign bus.axi1_awlen     = ch_aw[1] ? len_q : '0;
    assign bus.axi1_awuser_id = ch_aw[1] ? id_q : '0;
    assign bus.axi1_awuser_ap = ch_aw[1] & ap_q;
    assign bus.axi1_wdata     = ch_w[1] ? head[DATA_W-1:0] : '0;
    assign bus.axi1_wstrb     = ch_w[1] ? head[EntW-1:DATA_W] : '0;

    assign bus.axi2_awvalid   = ch_aw[2];
    assign bus.axi2_awaddr    = ch_aw[2] ? addr_q : '0;
    assign bus.axi2_awlen     = ch_aw[2] ? len_q : '0;
    assign bus.axi2_awuser_id = ch_aw[2] ? id_q : '0;
    assign bus.axi2_awuser_ap = ch_aw[2] & ap_q;
    assign bus.axi2_wdata     = ch_w[2] ? head[DATA_W-1:0] : '0;
    assign bus.axi2_wstrb     = ch_w[2] ? head[EntW-1:DATA_W] : '0;

`ifdef DDR3CH_DISPATCH_ERR_CNT_EN
    logic [15:0] err_q;
    always_ff @(posedge core_clk or negedge resetn) begin
        if (!resetn) begin
            err_q <= '0;
        end else if (state_q == StDrop && err_q != 16'hFFFF) begin
            err_q <= err_q + 16'd1;
        end
    end
    assign err_cnt = err_q;
`else
    assign err_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_ddr_3ch_wr_dispatch.sv
// Directed bench for ddr_3ch_wr_dispatch: routing, throttling, drop, init gating, reset.
`timescale 1ns/1ps
module tb_ddr_3ch_wr_dispatch;
    localparam int unsigned CAW = 28;
    localparam int unsigned DW  = 256;
    localparam int unsigned IW  = 8;
    localparam int unsigned LW  = 4;
`ifdef DDR3CH_DISPATCH_ERR_CNT_EN
    localparam logic [15:0] ErrAfterDrop = 16'd1;
`else
    localparam logic [15:0] ErrAfterDrop = 16'd0;
`endif

    logic core_clk = 1'b0;
    logic resetn = 1'b0;
    logic ddr_init_done = 1'b0;
    logic busy;
    logic [15:0] err_cnt;

    ddr_3ch_wr_dispatch_if #(.CTRL_ADDR_WIDTH(CAW), .DATA_W(DW), .ID_W(IW), .MAX_LEN_W(LW)) bus ();

    ddr_3ch_wr_dispatch #(.CTRL_ADDR_WIDTH(CAW), .DATA_W(DW), .ID_W(IW), .MAX_LEN_W(LW)) dut (
        .core_clk(core_clk), .resetn(resetn), .ddr_init_done(ddr_init_done), .bus(bus),
        .busy(busy), .err_cnt(err_cnt)
    );

    always #5 core_clk = ~core_clk;

    int n_checks = 0;
    int n_pass = 0;

    logic [DW-1:0]   got_data[$];
    logic [DW/8-1:0] got_strb[$];
    int aw_cycles, aw_first_cycle, accept_cycle, last_pop_cycle, busy_first_cycle, sent, pops;
    bit timeout, other_active, aw_unstable, gate_viol, busy_at_last_pop;
    logic [CAW-1:0] seen_awaddr;
    logic [LW-1:0]  seen_awlen;
    logic [IW-1:0]  seen_awid;
    logic           seen_ap;

    task automatic sample_ch(input int n, output logic awv, output logic [CAW-1:0] a,
                             output logic [LW-1:0] l, output logic [IW-1:0] i, output logic p,
                             output logic [DW-1:0] d, output logic [DW/8-1:0] s);
        case (n)
            0: begin awv = bus.axi0_awvalid; a = bus.axi0_awaddr; l = bus.axi0_awlen;
                i = bus.axi0_awuser_id; p = bus.axi0_awuser_ap; d = bus.axi0_wdata;
                s = bus.axi0_wstrb; end
            1: begin awv = bus.axi1_awvalid; a = bus.axi1_awaddr; l = bus.axi1_awlen;
                i = bus.axi1_awuser_id; p = bus.axi1_awuser_ap; d = bus.axi1_wdata;
                s = bus.axi1_wstrb; end
            default: begin awv = bus.axi2_awvalid; a = bus.axi2_awaddr; l = bus.axi2_awlen;
                i = bus.axi2_awuser_id; p = bus.axi2_awuser_ap; d = bus.axi2_wdata;
                s = bus.axi2_wstrb; end
        endcase
    endtask

    task automatic set_ch_ready(input int n, input logic awr, input logic wr);
        case (n)
            0: begin bus.axi0_awready = awr; bus.axi0_wready = wr; end
            1: begin bus.axi1_awready = awr; bus.axi1_wready = wr; end
            default: begin bus.axi2_awready = awr; bus.axi2_wready = wr; end
        endcase
    endtask

    task automatic clear_inputs();
        bus.h_awvalid = 1'b0; bus.h_wvalid = 1'b0; bus.h_awaddr = '0; bus.h_awlen = '0;
        bus.h_awid = '0; bus.h_awap = 1'b0; bus.h_wdata = '0; bus.h_wstrb = '0;
        for (int n = 0; n < 3; n++) set_ch_ready(n, 1'b0, 1'b0);
    endtask

    // Drives one host burst and plays the channel side; call just after a posedge.
    // Cycle 0 is the first cycle h_awvalid is presented.
    task automatic run_burst(input logic [CAW+1:0] addr, input logic [LW-1:0] len,
                             input logic [IW-1:0] id, input logic ap, input logic [DW-1:0] base,
                             input int aw_delay, input logic [31:0] wpat, input int wpat_len,
                             input int init_wait, input int stop_pops);
        int ch, data_idx;
        bit in_data, host_aw_done, done, legal;
        logic awv, p, awr, wr;
        logic [CAW-1:0] a;
        logic [LW-1:0] l;
        logic [IW-1:0] i;
        logic [DW-1:0] d;
        logic [DW/8-1:0] s;
        ch = int'(addr[CAW+1:CAW]);
        legal = (ch != 3);
        got_data.delete(); got_strb.delete();
        aw_cycles = 0; aw_first_cycle = -1; accept_cycle = -1; last_pop_cycle = -1;
        busy_first_cycle = -1; sent = 0; pops = 0;
        timeout = 0; other_active = 0; aw_unstable = 0; gate_viol = 0; busy_at_last_pop = 0;
        in_data = 0; host_aw_done = 0; done = 0; data_idx = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            ddr_init_done = (c >= init_wait);
            bus.h_awvalid = !host_aw_done;
            bus.h_awaddr = addr; bus.h_awlen = len; bus.h_awid = id; bus.h_awap = ap;
            bus.h_wvalid = (sent < int'(len) + 1);
            bus.h_wdata = base + DW'(sent);
            bus.h_wstrb = 32'hA5A5_0000 | 32'(sent);
            @(negedge core_clk);
            if (busy && busy_first_cycle < 0) busy_first_cycle = c;
            if (bus.h_awready && !ddr_init_done) gate_viol = 1;
            if (bus.h_awvalid && bus.h_awready) begin host_aw_done = 1; accept_cycle = c; end
            if (bus.h_wvalid && bus.h_wready) sent++;
            for (int n = 0; n < 3; n++) begin
                if (n != ch) begin
                    sample_ch(n, awv, a, l, i, p, d, s);
                    if (awv || d != '0 || s != '0) other_active = 1;
                    set_ch_ready(n, 1'b1, 1'b1);
                end
            end
            if (legal) begin
                sample_ch(ch, awv, a, l, i, p, d, s);
                wr = 1'b1;
                if (in_data) begin
                    wr = (data_idx < wpat_len) ? wpat[data_idx] : 1'b1;
                    data_idx++;
                    if (wr) begin
                        got_data.push_back(d); got_strb.push_back(s);
                        pops++; last_pop_cycle = c; busy_at_last_pop = busy;
                    end
                end
                awr = 1'b0;
                if (awv) begin
                    if (aw_cycles == 0) begin
                        aw_first_cycle = c;
                        seen_awaddr = a; seen_awlen = l; seen_awid = i; seen_ap = p;
                    end else if (a != seen_awaddr || l != seen_awlen || i != seen_awid ||
                                 p != seen_ap) begin
                        aw_unstable = 1;
                    end
                    aw_cycles++;
                    awr = (aw_cycles > aw_delay);
                    if (awr) in_data = 1;
                end
                set_ch_ready(ch, awr, wr);
                if (pops == int'(len) + 1 || (stop_pops > 0 && pops == stop_pops)) done = 1;
            end else if (sent == int'(len) + 1 && !busy) begin
                done = 1;
            end
            @(posedge core_clk); #1;
        end
        if (!done) timeout = 1;
        bus.h_awvalid = 1'b0; bus.h_wvalid = 1'b0;
        for (int n = 0; n < 3; n++) set_ch_ready(n, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        clear_inputs();
        resetn = 1'b0; ddr_init_done = 1'b1;
        repeat (2) @(posedge core_clk);
        @(negedge core_clk);
        n_checks++; if (bus.h_awready !== 1'b0) $display("FAIL reset_h_awready: got %b want 0", bus.h_awready); else n_pass++;
        n_checks++; if (bus.h_wready !== 1'b0) $display("FAIL reset_h_wready: got %b want 0", bus.h_wready); else n_pass++;
        n_checks++; if ({bus.axi0_awvalid, bus.axi1_awvalid, bus.axi2_awvalid} !== 3'b000) $display("FAIL reset_awvalid: got %b want 000", {bus.axi0_awvalid, bus.axi1_awvalid, bus.axi2_awvalid}); else n_pass++;
        n_checks++; if ((bus.axi0_wdata | bus.axi1_wdata | bus.axi2_wdata) !== '0 || bus.axi0_awaddr !== '0) $display("FAIL reset_axi_data: got %h want 0", bus.axi0_wdata | bus.axi1_wdata | bus.axi2_wdata); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (err_cnt !== 16'd0) $display("FAIL reset_err_cnt: got %h want 0", err_cnt); else n_pass++;
        resetn = 1'b1;
        @(posedge core_clk); #1;
    endtask

    task automatic test_basic_ch0();
        run_burst(30'h0000_0040, 4'd3, 8'h5A, 1'b0, 256'd1, 0, 32'h0, 0, 0, 0);
        n_checks++; if (timeout) $display("FAIL basic_timeout: got timeout want completion"); else n_pass++;
        n_checks++; if (seen_awaddr !== 28'h40 || seen_awlen !== 4'd3 || seen_awid !== 8'h5A || seen_ap !== 1'b0) $display("FAIL basic_aw_fields: got %h/%0d/%h/%b want 40/3/5a/0", seen_awaddr, seen_awlen, seen_awid, seen_ap); else n_pass++;
        n_checks++; if (got_data.size() !== 4) $display("FAIL basic_beat_count: got %0d want 4", got_data.size()); else n_pass++;
        for (int k = 0; k < got_data.size() && k < 4; k++) begin
            n_checks++; if (got_data[k] !== 256'(k + 1) || got_strb[k] !== (32'hA5A5_0000 | 32'(k))) $display("FAIL basic_beat%0d: got %h/%h want %0d/%h", k, got_data[k], got_strb[k], k + 1, 32'hA5A5_0000 | 32'(k)); else n_pass++;
        end
        n_checks++; if (other_active) $display("FAIL basic_other_channels: got activity want idle"); else n_pass++;
        n_checks++; if (aw_first_cycle !== 5 || aw_cycles !== 1) $display("FAIL basic_aw_cycle: got %0d (%0d cycles) want 5 (1)", aw_first_cycle, aw_cycles); else n_pass++;
        n_checks++; if (last_pop_cycle !== 9) $display("FAIL basic_last_pop_cycle: got %0d want 9", last_pop_cycle); else n_pass++;
        n_checks++; if (busy_first_cycle !== 1) $display("FAIL basic_busy_rise: got %0d want 1", busy_first_cycle); else n_pass++;
        @(negedge core_clk);
        n_checks++; if (bus.h_awready !== 1'b1 || busy !== 1'b0) $display("FAIL basic_back_to_idle: got awready=%b busy=%b want 1/0", bus.h_awready, busy); else n_pass++;
        @(posedge core_clk); #1;
    endtask

    task automatic test_ch2_throttled();
        run_burst({2'b10, 28'h123_4560}, 4'd0, 8'h33, 1'b1, 256'hBEEF, 5, 32'b100, 3, 0, 0);
        n_checks++; if (aw_cycles !== 6 || aw_unstable) $display("FAIL thr_aw_hold: got %0d cycles unstable=%b want 6 stable", aw_cycles, aw_unstable); else n_pass++;
        n_checks++; if (seen_awaddr !== 28'h123_4560 || seen_awlen !== 4'd0 || seen_ap !== 1'b1) $display("FAIL thr_aw_fields: got %h/%0d/%b want 1234560/0/1", seen_awaddr, seen_awlen, seen_ap); else n_pass++;
        n_checks++; if (got_data.size() !== 1 || got_data[0] !== 256'hBEEF) $display("FAIL thr_beat: got %0d beats first %h want 1 beat beef", got_data.size(), got_data.size() > 0 ? got_data[0] : '0); else n_pass++;
        n_checks++; if (last_pop_cycle !== 10) $display("FAIL thr_pop_cycle: got %0d want 10", last_pop_cycle); else n_pass++;
        n_checks++; if (other_active || timeout) $display("FAIL thr_isolation: got other=%b timeout=%b want 0/0", other_active, timeout); else n_pass++;
    endtask

    task automatic test_illegal_drop();
        run_burst({2'b11, 28'h0}, 4'd15, 8'h01, 1'b0, 256'h500, 0, 32'h0, 0, 0, 0);
        n_checks++; if (sent !== 16 || timeout) $display("FAIL drop_beats_consumed: got %0d timeout=%b want 16", sent, timeout); else n_pass++;
        n_checks++; if (other_active) $display("FAIL drop_no_channel_activity: got activity want none"); else n_pass++;
        n_checks++; if (err_cnt !== ErrAfterDrop) $display("FAIL drop_err_cnt: got %0d want %0d", err_cnt, ErrAfterDrop); else n_pass++;
        run_burst(30'h0000_0100, 4'd1, 8'h02, 1'b0, 256'd100, 0, 32'h0, 0, 0, 0);
        n_checks++; if (got_data.size() !== 2 || got_data[0] !== 256'd100 || got_data[1] !== 256'd101 || timeout) $display("FAIL drop_next_burst: got %0d beats want 100,101", got_data.size()); else n_pass++;
    endtask

    task automatic test_init_gate_backpressure();
        run_burst({2'b01, 28'h0000_0200}, 4'd2, 8'h77, 1'b0, 256'd40, 0, 32'b11001, 5, 3, 0);
        n_checks++; if (gate_viol) $display("FAIL gate_awready_low: got awready high while init low want low"); else n_pass++;
        n_checks++; if (accept_cycle !== 3) $display("FAIL gate_accept_cycle: got %0d want 3", accept_cycle); else n_pass++;
        n_checks++; if (got_data.size() !== 3 || got_data[0] !== 256'd40 || got_data[2] !== 256'd42 || timeout) $display("FAIL bp_beats: got %0d beats want 40..42", got_data.size()); else n_pass++;
        n_checks++; if (last_pop_cycle !== 12 || !busy_at_last_pop) $display("FAIL bp_pop_timing: got %0d busy=%b want 12 busy=1", last_pop_cycle, busy_at_last_pop); else n_pass++;
        @(negedge core_clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL bp_busy_fall: got %b want 0", busy); else n_pass++;
        @(posedge core_clk); #1;
    endtask

    task automatic test_reset_mid_data();
        run_burst({2'b01, 28'h0000_0800}, 4'd7, 8'h10, 1'b0, 256'h1000, 0, 32'h0, 0, 0, 2);
        n_checks++; if (got_data.size() !== 2 || got_data[1] !== 256'h1001) $display("FAIL rst_pre_beats: got %0d beats want 2", got_data.size()); else n_pass++;
        resetn = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || bus.axi1_wdata !== '0 || bus.axi1_wstrb !== '0 || bus.h_awready !== 1'b0 || bus.h_wready !== 1'b0) $display("FAIL rst_async_outputs: got busy=%b wdata=%h want all 0", busy, bus.axi1_wdata); else n_pass++;
        n_checks++; if (err_cnt !== 16'd0) $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); else n_pass++;
        #2 resetn = 1'b1;
        @(posedge core_clk); #1;
        run_burst({2'b01, 28'h0000_0020}, 4'd0, 8'h11, 1'b0, 256'h77, 0, 32'h0, 0, 0, 0);
        n_checks++; if (got_data.size() !== 1 || got_data[0] !== 256'h77 || timeout) $display("FAIL rst_fresh_burst: got %0d beats first %h want 1 beat 77", got_data.size(), got_data.size() > 0 ? got_data[0] : '0); else n_pass++;
        n_checks++; if (seen_awaddr !== 28'h20 || seen_awlen !== 4'd0) $display("FAIL rst_fresh_aw: got %h/%0d want 20/0", seen_awaddr, seen_awlen); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_ch0();
        test_ch2_throttled();
        test_illegal_drop();
        test_init_gate_backpressure();
        test_reset_mid_data();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
